// File: rtl/jogo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jogo_pkg: shared types, state codes and helpers for the game input |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package jogo_pkg;

    localparam int N_CHAVES_PADRAO = 4;
    localparam int LARGURA_MAX     = 32;

    typedef enum logic [2:0] {
        ESPERA      = 3'd0,
        CONTA_PRESS = 3'd1,
        PRESSIONADO = 3'd2,
        CONTA_SOLTA = 3'd3
    } estado_t;

    // Exactly one bit set; callers zero-extend narrower vectors.
    function automatic logic eh_one_hot(input logic [LARGURA_MAX-1:0] vec);
        return (vec != '0) && ((vec & (vec - 32'd1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sincronizador_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sincronizador_2ff: two-flop synchroniser for asynchronous levels   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sincronizador_2ff #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] sync1_q;
    logic [LARGURA-1:0] sync2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;

endmodule
`default_nettype wire

// File: rtl/detector_jogada.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | detector_jogada: debounces the button vector and reports one play  |
// | pulse per physical press, flagging non-one-hot presses.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int N_CHAVES        = N_CHAVES_PADRAO,
    parameter int DEBOUNCE_CICLOS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic                limpa,
    input  logic [N_CHAVES-1:0] chaves,
    output logic                jogada_feita,
    output logic                jogada_invalida,
    output logic [N_CHAVES-1:0] jogada,
    output logic                db_tem_jogada,
    output logic [2:0]          db_estado
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

    logic [N_CHAVES-1:0] chaves_s;

    estado_t             estado_q,   estado_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [N_CHAVES-1:0] amostra_q,  amostra_d;
    logic [N_CHAVES-1:0] jogada_q,   jogada_d;
    logic                feita_q,    feita_d;
    logic                invalida_q, invalida_d;
    logic                aceita;
    logic                amostra_oh;

    sincronizador_2ff #(
        .LARGURA (N_CHAVES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (chaves),
        .q     (chaves_s)
    );

    assign amostra_oh = eh_one_hot(LARGURA_MAX'(amostra_q));

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        amostra_d  = amostra_q;
        jogada_d   = jogada_q;
        feita_d    = 1'b0;
        invalida_d = 1'b0;
        aceita     = 1'b0;

        case (estado_q)
            ESPERA: begin
                if (chaves_s != '0) begin
                    amostra_d = chaves_s;
                    cnt_d     = '0;
                    estado_d  = CONTA_PRESS;
                end
            end
            CONTA_PRESS: begin
                if (chaves_s == '0) begin
                    cnt_d    = '0;
                    estado_d = ESPERA;
                end else if (chaves_s != amostra_q) begin
                    amostra_d = chaves_s;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_FIM) begin
                    aceita   = 1'b1;
                    cnt_d    = '0;
                    estado_d = PRESSIONADO;
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            PRESSIONADO: begin
                // Changes while held are ignored until every key is released.
                if (chaves_s == '0) begin
                    cnt_d    = '0;
                    estado_d = CONTA_SOLTA;
                end
            end
            CONTA_SOLTA: begin
                if (chaves_s != '0) begin
                    cnt_d    = '0;
                    estado_d = PRESSIONADO;
                end else if (cnt_q == CNT_FIM) begin
                    cnt_d    = '0;
                    estado_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            default: begin
                cnt_d    = '0;
                estado_d = ESPERA;
            end
        endcase

        // A valid accept takes priority over a simultaneous clear.
        if (aceita && habilita && amostra_oh) begin
            jogada_d = amostra_q;
            feita_d  = 1'b1;
        end else begin
            if (aceita && habilita) begin
                invalida_d = 1'b1;
            end
            if (limpa) begin
                jogada_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= ESPERA;
            cnt_q      <= '0;
            amostra_q  <= '0;
            jogada_q   <= '0;
            feita_q    <= 1'b0;
            invalida_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            amostra_q  <= amostra_d;
            jogada_q   <= jogada_d;
            feita_q    <= feita_d;
            invalida_q <= invalida_d;
        end
    end

    assign jogada_feita    = feita_q;
    assign jogada_invalida = invalida_q;
    assign jogada          = jogada_q;
    assign db_tem_jogada   = |chaves_s;
    assign db_estado       = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_detector_jogada.sv
`default_nettype none
`timescale 1us/1ns
// +--------------------------------------------------------------------+
// | tb_detector_jogada: scoreboard bench for detector_jogada           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic       limpa;
    logic [3:0] chaves;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic [3:0] jogada;
    logic       db_tem_jogada;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit         invalida;
        logic [3:0] jog;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    detector_jogada #(
        .N_CHAVES        (4),
        .DEBOUNCE_CICLOS (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .limpa           (limpa),
        .chaves          (chaves),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .jogada          (jogada),
        .db_tem_jogada   (db_tem_jogada),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #500 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nome, atual, esperado, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expect a pulse 5 cycles after the input changes at the current negedge.
    task automatic espera_pulso(input bit inv, input logic [3:0] jog, input int atraso);
        exp_t e;
        e.invalida = inv;
        e.jog      = jog;
        e.cyc      = cyc + atraso;
        sb.push_back(e);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            if (jogada_feita && jogada_invalida) begin
                chk("both_pulses", 1, 0);
            end
            if (jogada_feita || jogada_invalida) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_cycle",  cyc, e.cyc);
                    chk("pulse_kind",   int'(jogada_invalida), int'(e.invalida));
                    chk("pulse_jogada", int'(jogada), int'(e.jog));
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        habilita = 1'b0;
        limpa    = 1'b0;
        chaves   = 4'b0000;

        // 1. reset and idle
        tick(10);
        chk("rst_feita",    int'(jogada_feita), 0);
        chk("rst_invalida", int'(jogada_invalida), 0);
        chk("rst_jogada",   int'(jogada), 0);
        chk("rst_estado",   int'(db_estado), 0);
        chk("rst_tem",      int'(db_tem_jogada), 0);
        reset = 1'b1;
        tick(20);
        chk("idle_estado", int'(db_estado), 0);
        chk("idle_jogada", int'(jogada), 0);

        // 2. clean single press
        habilita = 1'b1;
        chaves   = 4'b0001;
        espera_pulso(1'b0, 4'b0001, 5);
        tick(5);
        chaves = 4'b0000;
        tick(6);
        chk("t2_jogada", int'(jogada), 1);
        chk("t2_estado", int'(db_estado), 0);

        // 3. bouncing press
        for (int i = 0; i < 6; i++) begin
            chaves = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            tick(1);
        end
        chaves = 4'b0100;
        espera_pulso(1'b0, 4'b0100, 5);
        tick(8);
        chaves = 4'b0000;
        tick(6);
        chk("t3_jogada", int'(jogada), 4);

        // 4. two keys at once
        chaves = 4'b0110;
        espera_pulso(1'b1, 4'b0100, 5);
        tick(8);
        chaves = 4'b0000;
        tick(6);
        chk("t4_jogada", int'(jogada), 4);

        // 5. press already held when enabled is ignored
        habilita = 1'b0;
        chaves   = 4'b1000;
        tick(6);
        habilita = 1'b1;
        tick(4);
        chaves = 4'b0000;
        tick(6);
        chk("t5_jogada_hold", int'(jogada), 4);
        chaves = 4'b1000;
        espera_pulso(1'b0, 4'b1000, 5);
        tick(5);
        chaves = 4'b0000;
        tick(6);
        chk("t5_jogada", int'(jogada), 8);

        // 6. long hold, reset mid-hold, re-press after reset, limpa
        chaves = 4'b0010;
        espera_pulso(1'b0, 4'b0010, 5);
        tick(20);
        chk("t6_estado_hold", int'(db_estado), 2);
        chk("t6_tem",         int'(db_tem_jogada), 1);
        reset = 1'b0;
        tick(1);
        chk("t6_rst_jogada", int'(jogada), 0);
        chk("t6_rst_estado", int'(db_estado), 0);
        chk("t6_rst_tem",    int'(db_tem_jogada), 0);
        tick(3);
        reset = 1'b1;
        espera_pulso(1'b0, 4'b0010, 5);
        tick(8);
        chaves = 4'b0000;
        tick(6);
        chk("t6_jogada_rearm", int'(jogada), 2);

        chaves = 4'b0001;
        espera_pulso(1'b0, 4'b0001, 5);
        tick(4);
        limpa = 1'b1;
        tick(1);
        limpa = 1'b0;
        chk("t6_limpa_accept", int'(jogada), 1);
        tick(2);
        chaves = 4'b0000;
        tick(6);
        limpa = 1'b1;
        tick(1);
        limpa = 1'b0;
        chk("t6_limpa_alone", int'(jogada), 0);
        tick(4);

        chk("pending_pulses", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
